// File: rtl/uart_loader.sv
`default_nettype none
// uart_loader: reads a big-endian word count and that many big-endian words from the
// UART byte interface, writes them to instruction memory from address 0, then replies ACK/NAK.
module uart_loader #(
  parameter int         ADDR_W   = 15,
  parameter logic [7:0] ACK_BYTE = 8'hAA,
  parameter logic [7:0] NAK_BYTE = 8'h55
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              uio_ren,
  input  logic [7:0]        uio_rdata,
  input  logic              uio_rdone,
  output logic              uio_wen,
  output logic [7:0]        uio_wdata,
  input  logic              uio_wdone,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   loaded
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HDR_REQ   = 4'd1,
    HDR_WAIT  = 4'd2,
    CHK       = 4'd3,
    DATA_REQ  = 4'd4,
    DATA_WAIT = 4'd5,
    WR        = 4'd6,
    ACK_REQ   = 4'd7,
    ACK_WAIT  = 4'd8,
    FIN       = 4'd9
  } state_t;

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  state_t            state, state_nx;
  logic [1:0]        bcnt, bcnt_nx;
  logic [31:0]       sr, sr_nx;
  logic [31:0]       len, len_nx;
  logic [ADDR_W:0]   loaded_nx;
  logic              err_nx;
  logic [7:0]        wdata_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       imem_wdata_nx;

  logic [31:0]       sr_shift;
  logic [ADDR_W:0]   loaded_inc;
  logic [31:0]       loaded_inc32;

  assign sr_shift     = {sr[23:0], uio_rdata};
  assign loaded_inc   = loaded + {{ADDR_W{1'b0}}, 1'b1};
  assign loaded_inc32 = 32'(loaded_inc);

  always_comb begin
    state_nx      = state;
    bcnt_nx       = bcnt;
    sr_nx         = sr;
    len_nx        = len;
    loaded_nx     = loaded;
    err_nx        = err;
    wdata_nx      = uio_wdata;
    addr_nx       = imem_addr;
    imem_wdata_nx = imem_wdata;

    case (state)
      IDLE: begin
        if (start) begin
          err_nx    = 1'b0;
          loaded_nx = '0;
          bcnt_nx   = 2'd0;
          sr_nx     = 32'd0;
          state_nx  = HDR_REQ;
        end
      end
      HDR_REQ:  state_nx = HDR_WAIT;
      DATA_REQ: state_nx = DATA_WAIT;
      HDR_WAIT: begin
        if (uio_rdone) begin
          sr_nx    = sr_shift;
          bcnt_nx  = bcnt + 2'd1;
          state_nx = (bcnt == 2'd3) ? CHK : HDR_REQ;
        end
      end
      DATA_WAIT: begin
        if (uio_rdone) begin
          sr_nx   = sr_shift;
          bcnt_nx = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            // Stage the completed word so imem_we lands in the cycle right after rdone.
            addr_nx       = loaded[ADDR_W-1:0];
            imem_wdata_nx = sr_shift;
            state_nx      = WR;
          end else begin
            state_nx = DATA_REQ;
          end
        end
      end
      CHK: begin
        len_nx = sr;
        if (sr == 32'd0) begin
          wdata_nx = ACK_BYTE;
          state_nx = ACK_REQ;
        end else if ({1'b0, sr} > CAPACITY) begin
          err_nx   = 1'b1;
          wdata_nx = NAK_BYTE;
          state_nx = ACK_REQ;
        end else begin
          state_nx = DATA_REQ;
        end
      end
      WR: begin
        loaded_nx = loaded_inc;
        if (loaded_inc32 == len) begin
          wdata_nx = ACK_BYTE;
          state_nx = ACK_REQ;
        end else begin
          state_nx = DATA_REQ;
        end
      end
      ACK_REQ:  state_nx = ACK_WAIT;
      ACK_WAIT: if (uio_wdone) state_nx = FIN;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bcnt       <= 2'd0;
      sr         <= 32'd0;
      len        <= 32'd0;
      loaded     <= '0;
      err        <= 1'b0;
      uio_wdata  <= 8'h00;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      uio_ren    <= 1'b0;
      uio_wen    <= 1'b0;
      imem_we    <= 1'b0;
    end else begin
      state      <= state_nx;
      bcnt       <= bcnt_nx;
      sr         <= sr_nx;
      len        <= len_nx;
      loaded     <= loaded_nx;
      err        <= err_nx;
      uio_wdata  <= wdata_nx;
      imem_addr  <= addr_nx;
      imem_wdata <= imem_wdata_nx;
      busy       <= (state_nx != IDLE);
      done       <= (state_nx == FIN);
      uio_ren    <= (state_nx == HDR_REQ) || (state_nx == DATA_REQ);
      uio_wen    <= (state_nx == ACK_REQ);
      imem_we    <= (state_nx == WR);
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader that sits directly downstream of the UART byte interface block (`uart_io`) and feeds the core's instruction memory. On `start` it reads a 4-byte big-endian word count from the byte stream, then that many 32-bit big-endian words. It writes each word to consecutive instruction-memory addresses from 0, sends a one-byte acknowledge back through the same byte interface, and pulses `done`.

## Interface
- `ADDR_W`, 15, instruction-memory word-address width; capacity is 2^ADDR_W words.
- `ACK_BYTE`, 8'hAA, byte sent after a successful load.
- `NAK_BYTE`, 8'h55, byte sent when the header exceeds capacity.
- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse at the end of a load, whether it succeeded or failed.
- `err`  out  1  set on an oversize header; cleared on the next accepted `start`.
- `uio_ren`  out  1  one-cycle byte-read request to the byte interface.
- `uio_rdata`  in  8  received byte; valid only in the cycle `uio_rdone` is high.
- `uio_rdone`  in  1  one-cycle read-complete pulse.
- `uio_wen`  out  1  one-cycle byte-write request.
- `uio_wdata`  out  8  byte to send; held stable from `uio_wen` until `uio_wdone`.
- `uio_wdone`  in  1  one-cycle write-accepted pulse.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address for `imem_we`.
- `imem_wdata`  out  32  word for `imem_we`.
- `loaded`  out  ADDR_W+1  number of words written in the current or most recent load.

## Operation
- **States:**
  - IDLE
  - HDR_REQ, HDR_WAIT: read the header.
  - CHK: check the length.
  - DATA_REQ, DATA_WAIT: read a data word.
  - WR: write the word.
  - ACK_REQ, ACK_WAIT: send the response byte.
  - FIN: end of load.
- **IDLE:**
  - On `start`, clear `err`, `loaded`, the byte counter `bcnt` (2 bits) and the shift register.
  - Go to HDR_REQ.
- **Read request (HDR_REQ / DATA_REQ):**
  - Drive `uio_ren`=1 for exactly this cycle, then go to the matching WAIT state.
- **Read wait (HDR_WAIT / DATA_WAIT):**
  - Hold until `uio_rdone`, then shift: `sr <= {sr[23:0], uio_rdata}` and `bcnt <= bcnt+1`.
  - If `bcnt` was 3: from HDR_WAIT go to CHK; from DATA_WAIT go to WR.
  - Otherwise return to the matching REQ state.
- **CHK:** latch `len <= sr`, then branch:
  - `sr` = 0: go to ACK_REQ with `ACK_BYTE`.
  - `sr` > 2^ADDR_W: set `err`=1 and go to ACK_REQ with `NAK_BYTE`. No data is read.
  - Otherwise: go to DATA_REQ.
- **WR:**
  - `imem_we`=1, `imem_addr`=`loaded[ADDR_W-1:0]`, `imem_wdata`=`sr`.
  - Next cycle `loaded <= loaded+1`.
  - If the new `loaded` equals `len`, go to ACK_REQ with `ACK_BYTE`; else go to DATA_REQ.
- **ACK_REQ:** `uio_wen`=1 for one cycle with `uio_wdata` loaded, then go to ACK_WAIT.
- **ACK_WAIT:** hold until `uio_wdone`, then go to FIN.
- **FIN:** `done`=1 for one cycle, then go to IDLE.
- **Stray and overlapping inputs:**
  - `uio_rdone` outside the WAIT states and `uio_wdone` outside ACK_WAIT are ignored.
  - `start` while `busy` is ignored.
- **At most one outstanding request.** A new `uio_ren` is never issued before the previous `uio_rdone`. The loader tracks outstanding requests through its own state; it never samples the byte interface's busy flags.
- **Address wrap:** with `len` = 2^ADDR_W, the last write goes to address 2^ADDR_W−1. `imem_addr` never wraps within a load.
- **Reset mid-load:**
  - All outputs return to their reset values and the state goes to IDLE. No partial word is written.
  - Bytes already consumed from the byte interface are lost; the host must resend the whole image.

## Timing
- **Reset values:**
  - `busy`, `done`, `err`, `uio_ren`, `uio_wen`, `imem_we` = 0.
  - `uio_wdata` = 8'h00, `imem_addr` = 0, `imem_wdata` = 0, `loaded` = 0.
- All outputs are registered.
- `busy` rises the cycle after `start` and falls the cycle after the `done` pulse.
- **Per byte:** `uio_ren` falls the cycle after it rises. The next `uio_ren` is issued no earlier than the cycle after `uio_rdone` (REQ → WAIT → REQ is 2 cycles minimum).
- **Word write:** `imem_we` asserts exactly 1 cycle after the `uio_rdone` that delivers byte 3 of the word.
- **Minimum load of N words** (byte interface answering in 1 cycle): 1 + 8 + 1 + N·9 + 2 + 1 cycles from `start` to `done`.
- **Data retention:** `imem_wdata` and `imem_addr` hold their last values after `imem_we` drops. `loaded` holds until the next `start`.

## Test plan
- **Two-word load:**
  - Stimulus: `start`; bytes 00 00 00 02, DE AD BE EF, 01 23 45 67.
  - Required: `imem_we` at addr 0 with 32'hDEADBEEF, then at addr 1 with 32'h01234567; `uio_wdata`=8'hAA; `done` pulse; `loaded`=2; `err`=0.
- **Zero length:**
  - Stimulus: header 00 00 00 00.
  - Required: no `imem_we`; ACK 8'hAA; `done`; `loaded`=0.
- **Oversize header:**
  - Stimulus: ADDR_W=4, header 00 00 00 11.
  - Required: `err`=1; NAK 8'h55; no further `uio_ren` after the header; `done`.
- **Full capacity:**
  - Stimulus: ADDR_W=4, header 00 00 00 10, 16 words.
  - Required: last write at addr 4'hF; `loaded`=16; ACK sent.
- **Stray pulses:**
  - Stimulus: extra `uio_rdone` pulses in DATA_REQ/WR cycles, and `start` pulses while `busy`.
  - Required: no extra shifts and no restart; data identical to the two-word case.
- **Reset mid-load:**
  - Stimulus: `rstn` low after byte 2 of word 0.
  - Required: all outputs at reset values asynchronously; no `imem_we`; a fresh `start` loads correctly.
